// File: rtl/branch_pred_chooser.sv
// Tournament chooser: per-PC saturating confidence counters pick one of NUM_PRED
// component predictions at lookup and are trained against the actual outcome at resolve.
module branch_pred_chooser #(
   parameter int NUM_PRED = 2,
   parameter int IDX_W    = 4,
   parameter int CONF_W   = 2,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lookup_valid,
   input  logic [31:0]         lookup_pc,
   input  logic [NUM_PRED-1:0] lookup_pred,
   output logic                pred_valid,
   output logic                pred_taken,
   output logic [2:0]          pred_sel,
   input  logic                res_valid,
   input  logic [31:0]         res_inst,
   input  logic [31:0]         res_pc,
   input  logic                res_taken,
   input  logic [NUM_PRED-1:0] res_pred,
   input  logic                res_final,
   output logic                hit_valid,
   output logic [NUM_PRED-1:0] hit_vec,
   output logic                final_hit,
   output logic [CNT_W-1:0]    branch_cnt,
   output logic [CNT_W-1:0]    mispred_cnt
);

   // Requests are single-cycle valid pulses with no ready: every asserted valid is
   // accepted on that edge, and each result valid is high for exactly one cycle after it.

   localparam int                DEPTH     = 1 << IDX_W;
   localparam logic [CONF_W-1:0] CONF_MAX  = '1;
   localparam logic [CONF_W-1:0] CONF_INIT = CONF_W'(1 << (CONF_W - 1));
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [6:0]        OP_BRANCH = 7'b1100011;

   typedef logic [NUM_PRED-1:0][CONF_W-1:0] entry_t;

   entry_t              conf [DEPTH];
   logic [IDX_W-1:0]    lk_idx;
   logic [IDX_W-1:0]    rs_idx;
   logic                is_branch;
   entry_t              lk_entry;
   logic [2:0]          best_sel;
   logic [CONF_W-1:0]   best_conf;
   logic                best_taken;
   entry_t              rs_entry;
   entry_t              rs_next;
   logic [NUM_PRED-1:0] rs_hit;
   logic                unused_bits;

   assign lk_idx      = lookup_pc[IDX_W+1:2];
   assign rs_idx      = res_pc[IDX_W+1:2];
   assign is_branch   = res_valid && (res_inst[6:0] == OP_BRANCH);
   assign unused_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                          res_pc[31:IDX_W+2], res_pc[1:0], res_inst[31:7]};

   // Strictly-greater compare keeps the lowest index on ties.
   always_comb begin
      lk_entry   = conf[lk_idx];
      best_sel   = 3'd0;
      best_conf  = lk_entry[0];
      best_taken = lookup_pred[0];
      for (int i = 1; i < NUM_PRED; i++) begin
         if (lk_entry[i] > best_conf) begin
            best_sel   = 3'(i);
            best_conf  = lk_entry[i];
            best_taken = lookup_pred[i];
         end
      end
   end

   always_comb begin
      rs_entry = conf[rs_idx];
      rs_hit   = ~(res_pred ^ {NUM_PRED{res_taken}});
      rs_next  = rs_entry;
      for (int i = 0; i < NUM_PRED; i++) begin
         if (rs_hit[i]) begin
            if (rs_entry[i] != CONF_MAX) rs_next[i] = rs_entry[i] + 1'b1;
         end else begin
            if (rs_entry[i] != '0) rs_next[i] = rs_entry[i] - 1'b1;
         end
      end
   end

   // Lookup reads the registered table, so a same-cycle resolve is seen one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < DEPTH; e++) begin
            conf[e] <= {NUM_PRED{CONF_INIT}};
         end
      end else if (is_branch) begin
         conf[rs_idx] <= rs_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pred_valid  <= 1'b0;
         pred_taken  <= 1'b0;
         pred_sel    <= 3'd0;
         hit_valid   <= 1'b0;
         hit_vec     <= '0;
         final_hit   <= 1'b0;
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         pred_valid <= lookup_valid;
         if (lookup_valid) begin
            pred_sel   <= best_sel;
            pred_taken <= best_taken;
         end
         hit_valid <= is_branch;
         if (is_branch) begin
            hit_vec   <= rs_hit;
            final_hit <= (res_final == res_taken);
            if (branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + 1'b1;
            if ((res_final != res_taken) && (mispred_cnt != CNT_MAX)) begin
               mispred_cnt <= mispred_cnt + 1'b1;
            end
         end else if (res_valid) begin
            final_hit <= 1'b0;
         end
      end
   end

endmodule

// File: doc/branch_pred_chooser.md
# branch_pred_chooser

Parametrised tournament chooser and resolution tracker for the conditional-branch predictors. It holds a table of per-predictor saturating confidence counters, indexed by PC. At lookup it picks which of NUM_PRED component predictions to use. At resolve it scores every component against the actual outcome, updates the confidence table and keeps branch/mispredict statistics. It sits between the component predictors in fetch and the branch comparator in execute.

## Interface
Parameters:
- NUM_PRED, 2: number of component predictors (2..8).
- IDX_W, 4: chooser table index width; table depth is 2^IDX_W.
- CONF_W, 2: width of each confidence counter (1..4).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  32  PC of the fetched branch.
- lookup_pred  in  NUM_PRED  component predictions, bit i = predictor i says taken.
- pred_valid  out  1  registered lookup result is valid.
- pred_taken  out  1  final chosen prediction.
- pred_sel  out  3  index of the chosen predictor.
- res_valid  in  1  resolve request this cycle.
- res_inst  in  32  resolved instruction word.
- res_pc  in  32  PC of the resolved instruction.
- res_taken  in  1  actual branch outcome (PCsel).
- res_pred  in  NUM_PRED  component predictions made for this branch.
- res_final  in  1  final prediction made for this branch.
- hit_valid  out  1  registered resolve result is valid.
- hit_vec  out  NUM_PRED  bit i = predictor i was correct.
- final_hit  out  1  final prediction was correct.
- branch_cnt  out  CNT_W  resolved conditional branches.
- mispred_cnt  out  CNT_W  resolved branches with res_final != res_taken.

## Operation
- Table index is pc[IDX_W+1:2], used for both lookup and resolve.
- Each table entry holds NUM_PRED counters, each CONF_W bits wide.
- Lookup:
  - Select the predictor with the highest counter at the indexed entry.
  - On a tie, the lowest index wins.
  - pred_taken = lookup_pred[sel].
- Resolve applies only when res_valid=1 and res_inst[6:0]==7'b1100011.
  - For each predictor i: counter += 1 if res_pred[i]==res_taken, saturating at 2^CONF_W-1. Otherwise counter -= 1, saturating at 0.
  - hit_vec[i] = (res_pred[i]==res_taken).
  - final_hit = (res_final==res_taken).
  - branch_cnt += 1.
  - mispred_cnt += 1 if res_final != res_taken.
  - Both statistics counters saturate at all-ones; they do not wrap.
- Non-branch resolve (res_valid=1, opcode not 1100011):
  - No table or statistics update.
  - hit_valid=0 and final_hit=0.
  - hit_vec holds its previous value.
- res_valid=0: hit_valid=0; hit_vec and final_hit hold.
- lookup_valid=0: pred_valid=0; pred_taken and pred_sel hold.
- Lookup and resolve to the same index in the same cycle: lookup reads the pre-update counters (read-before-write). The update is visible to a lookup one cycle later.
- No backpressure; a new request of either kind is accepted every cycle.

## Timing
- Reset (asynchronous, immediate):
  - All confidence counters = 2^(CONF_W-1) (weakly confident).
  - pred_valid, pred_taken, pred_sel = 0.
  - hit_valid, hit_vec, final_hit = 0.
  - branch_cnt, mispred_cnt = 0.
- Lookup latency 1: lookup_valid at edge t → pred_valid/pred_taken/pred_sel valid after edge t, for one cycle.
- Resolve latency 1: res_valid at edge t → hit_valid/hit_vec/final_hit after edge t. Table and statistics update at edge t.
- Reset asserted mid-stream discards in-flight results. Any request coinciding with rst is ignored.
- After rst deasserts, the first edge with a request behaves normally.

## Test plan
- Reset: assert rst asynchronously between edges → all outputs 0 immediately. A following lookup at any PC returns pred_sel=0 (tie at 2).
- Chooser training (NUM_PRED=2, CONF_W=2):
  - 3 branch resolves at pc=0x40 with res_pred=2'b10, res_taken=1.
  - Predictor 1 counter → 3 (saturated), predictor 0 counter → 0.
  - Lookup at pc=0x40 with lookup_pred=2'b10 → pred_sel=1, pred_taken=1.
  - Lookup at pc=0x44 → pred_sel=0.
- Non-branch: res_valid with res_inst opcode 0110011 → hit_valid=0, final_hit=0, hit_vec unchanged, branch_cnt unchanged.
- Statistics: 5 branches with res_final matching res_taken on 3 → branch_cnt=5, mispred_cnt=2. With CNT_W=3, 9 branches → branch_cnt=7 (saturated).
- Same-cycle hazard: lookup and resolve at pc=0x80 in the same cycle → lookup uses old counters. A lookup one cycle later reflects the update.
- Parametrisation: NUM_PRED=4, CONF_W=3, counters tied at 4 → pred_sel=0. After one resolve with res_pred=4'b1000 correct (taken=1) → predictor 3 counter = 5, others 3 → pred_sel=3.
